// File: rtl/service_4_alarm_sequencer.sv
// Service 4 alarm sequencer: arms on SPDT4, rings at the alarm time, runs the
// LED-matching mini-game and schedules snoozes until the player wins.
module service_4_alarm_sequencer #(
   parameter int          ROUND_CYCLES = 10,
   parameter int          WIN_ROUNDS   = 3,
   parameter int          SNOOZE_STEP  = 5,
   parameter int          MAX_SNOOZE   = 3,
   parameter logic [9:0]  LFSR_SEED    = 10'h2A5
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        SPDT4,
   input  logic [15:0] current,
   input  logic [15:0] alarm,
   input  logic        push_m,
   input  logic [9:0]  SPDTs,
   output logic [2:0]  alarm_state,
   output logic        mini_game,
   output logic        ringing,
   output logic [9:0]  random_led,
   output logic [15:0] count_state,
   output logic [1:0]  snooze_cnt,
   output logic        dismissed
);

   localparam int            TW   = $clog2(ROUND_CYCLES);
   localparam logic [TW-1:0] TMAX = TW'(ROUND_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'b000,
      ARMED  = 3'b001,
      RING   = 3'b010,
      SNOOZE = 3'b011,
      GAME   = 3'b100,
      DONE   = 3'b101
   } state_e;

   state_e        state_q, state_d;
   logic [15:0]   target_q, target_d;
   logic [9:0]    lfsr_q, lfsr_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          wait_q, wait_d;
   logic          push_q, push_d;
   logic [15:0]   count_q, count_d;
   logic [1:0]    snooze_q, snooze_d;
   logic [9:0]    rled_q, rled_d;
   logic          dis_q, dis_d;
   logic          new_round;
   logic          push_edge;

   function automatic logic [9:0] pick_led(input logic [9:0] l);
      pick_led = 10'd1 << (l % 10'd10);
   endfunction

   assign push_edge = push_m & ~push_q;

   always_comb begin
      state_d   = state_q;
      target_d  = target_q;
      lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      timer_d   = timer_q;
      wait_d    = wait_q;
      push_d    = push_m;
      count_d   = count_q;
      snooze_d  = snooze_q;
      rled_d    = rled_q;
      dis_d     = 1'b0;
      new_round = 1'b0;

      if (!SPDT4) begin
         state_d  = IDLE;
         snooze_d = 2'd0;
         count_d  = 16'd0;
         rled_d   = 10'd0;
         wait_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d  = ARMED;
               target_d = alarm;
            end
            ARMED: begin
               target_d = alarm;
               if (current == target_q) state_d = RING;
            end
            RING: begin
               if (push_edge) begin
                  state_d   = GAME;
                  count_d   = 16'd0;
                  new_round = 1'b1;
               end
            end
            GAME: begin
               if (wait_q) begin
                  // Switches must all drop before the next round is dealt.
                  if (SPDTs == 10'd0) new_round = 1'b1;
               end else if (SPDTs == rled_q) begin
                  count_d = count_q + 16'd1;
                  if (count_q + 16'd1 == 16'(WIN_ROUNDS)) begin
                     state_d = DONE;
                     dis_d   = 1'b1;
                     rled_d  = 10'd0;
                  end else begin
                     wait_d = 1'b1;
                  end
               end else if (timer_q == '0) begin
                  count_d = 16'd0;
                  if (snooze_q < 2'(MAX_SNOOZE)) begin
                     state_d  = SNOOZE;
                     snooze_d = snooze_q + 2'd1;
                     target_d = current + 16'(SNOOZE_STEP);
                     rled_d   = 10'd0;
                  end else begin
                     new_round = 1'b1;
                  end
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            SNOOZE: begin
               if (current == target_q) state_d = RING;
            end
            DONE: begin
               snooze_d = 2'd0;
               // Wait for the minute to move on so the same time can't re-trigger.
               if (current != alarm) begin
                  state_d  = ARMED;
                  target_d = alarm;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (new_round) begin
         rled_d  = pick_led(lfsr_q);
         timer_d = TMAX;
         wait_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q  <= IDLE;
         target_q <= 16'd0;
         lfsr_q   <= LFSR_SEED;
         timer_q  <= '0;
         wait_q   <= 1'b0;
         push_q   <= 1'b0;
         count_q  <= 16'd0;
         snooze_q <= 2'd0;
         rled_q   <= 10'd0;
         dis_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         lfsr_q   <= lfsr_d;
         timer_q  <= timer_d;
         wait_q   <= wait_d;
         push_q   <= push_d;
         count_q  <= count_d;
         snooze_q <= snooze_d;
         rled_q   <= rled_d;
         dis_q    <= dis_d;
      end
   end

   assign alarm_state = state_q;
   assign mini_game   = (state_q == GAME);
   assign ringing     = (state_q == RING);
   assign random_led  = rled_q;
   assign count_state = count_q;
   assign snooze_cnt  = snooze_q;
   assign dismissed   = dis_q;

endmodule
